// File: rtl/fir_tap_loader.sv
// fir_tap_loader: drains FIR tap words from the track-parameter FIFO into a
// shadow coefficient bank, checks the burst length on burst end, and commits
// a good burst by swapping it into the active bank read by the FIR datapath.
//
// Optional feature macro: FIR_TAP_SWAP_ON_ZERO_EN
//   defined   - a good burst waits in PEND for laser_zero_flag_i before the swap
//   undefined - a good burst is swapped in immediately after CHECK
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   track_para_burst_end_i  one-cycle burst-complete pulse from upstream
//   track_para_vld_i        FIFO read data valid
//   track_para_data_i       FIFO read data (one tap word)
//   track_para_ren_o        FIFO read enable
//   laser_zero_flag_i       spindle zero-angle pulse, commit point (PEND only)
//   tap_rd_addr_i           coefficient read address into the active bank
//   tap_rd_data_o           registered active-bank tap, 1-cycle latency
//   tap_bank_o              index of the active bank
//   tap_valid_o             high once any burst has been committed
//   tap_update_o            one-cycle pulse on each bank swap
//   burst_err_o             one-cycle pulse on a bad burst length
//   burst_err_cnt_o         saturating count of bad bursts
module fir_tap_loader #(
    parameter int unsigned TAP_NUM    = 128,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  track_para_burst_end_i,
    input  logic                  track_para_vld_i,
    input  logic [DATA_WIDTH-1:0] track_para_data_i,
    output logic                  track_para_ren_o,
    input  logic                  laser_zero_flag_i,
    input  logic [6:0]            tap_rd_addr_i,
    output logic [DATA_WIDTH-1:0] tap_rd_data_o,
    output logic                  tap_bank_o,
    output logic                  tap_valid_o,
    output logic                  tap_update_o,
    output logic                  burst_err_o,
    output logic [15:0]           burst_err_cnt_o
);

    localparam int unsigned AW       = $clog2(TAP_NUM);
    localparam int unsigned DEPTH    = 2 * TAP_NUM;
    localparam logic [7:0]  CNT_FULL = 8'(TAP_NUM);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CHECK  = 3'd2,
        PEND   = 3'd3,
        COMMIT = 3'd4
    } state_t;

    state_t                state;
    logic [7:0]            wr_cnt;
    logic                  end_latched;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept_c;
    logic                  write_c;
    logic                  start_check_c;
    logic [7:0]            cnt_next_c;
    logic [AW:0]           wr_addr_c;
    logic [AW:0]           rd_addr_c;

    // Word acceptance, saturating count including the word of this cycle, and
    // RAM addressing: bank select is the MSB, shadow = ~active.
    always_comb begin
        accept_c      = track_para_vld_i && ((state == IDLE) || (state == LOAD));
        write_c       = accept_c && (wr_cnt < CNT_FULL) && !rst_i;
        cnt_next_c    = (accept_c && (wr_cnt != 8'hFF)) ? wr_cnt + 8'd1 : wr_cnt;
        start_check_c = track_para_burst_end_i || ((state == IDLE) && end_latched);
        wr_addr_c     = {~tap_bank_o, wr_cnt[AW-1:0]};
        rd_addr_c     = {tap_bank_o, tap_rd_addr_i[AW-1:0]};
    end

    // Control FSM; the length verdict is taken on entry to CHECK so the error
    // pulse shows during the CHECK cycle, and the bank toggles on entry to
    // COMMIT so tap_update_o and the new bank index appear together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            wr_cnt           <= 8'd0;
            end_latched      <= 1'b0;
            track_para_ren_o <= 1'b1;
            tap_bank_o       <= 1'b0;
            tap_valid_o      <= 1'b0;
            tap_update_o     <= 1'b0;
            burst_err_o      <= 1'b0;
            burst_err_cnt_o  <= 16'd0;
        end else begin
            tap_update_o <= 1'b0;
            burst_err_o  <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    wr_cnt <= cnt_next_c;
                    if (start_check_c) begin
                        state            <= CHECK;
                        track_para_ren_o <= 1'b0;
                        end_latched      <= 1'b0;
                        if (cnt_next_c != CNT_FULL) begin
                            burst_err_o <= 1'b1;
                            if (burst_err_cnt_o != 16'hFFFF) begin
                                burst_err_cnt_o <= burst_err_cnt_o + 16'd1;
                            end
                        end
                    end else if (accept_c) begin
                        state <= LOAD;
                    end
                end
                CHECK: begin
                    if (track_para_burst_end_i) end_latched <= 1'b1;
                    if (wr_cnt == CNT_FULL) begin
`ifdef FIR_TAP_SWAP_ON_ZERO_EN
                        state <= PEND;
`else
                        state        <= COMMIT;
                        tap_bank_o   <= ~tap_bank_o;
                        tap_update_o <= 1'b1;
                        tap_valid_o  <= 1'b1;
`endif
                    end else begin
                        wr_cnt           <= 8'd0;
                        state            <= IDLE;
                        track_para_ren_o <= 1'b1;
                    end
                end
                PEND: begin
                    if (track_para_burst_end_i) end_latched <= 1'b1;
                    if (laser_zero_flag_i) begin
                        state        <= COMMIT;
                        tap_bank_o   <= ~tap_bank_o;
                        tap_update_o <= 1'b1;
                        tap_valid_o  <= 1'b1;
                    end
                end
                COMMIT: begin
                    if (track_para_burst_end_i) end_latched <= 1'b1;
                    wr_cnt           <= 8'd0;
                    state            <= IDLE;
                    track_para_ren_o <= 1'b1;
                end
                default: begin
                    state            <= IDLE;
                    track_para_ren_o <= 1'b1;
                end
            endcase
        end
    end

    // Coefficient RAM write port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (write_c) begin
            mem[wr_addr_c] <= track_para_data_i;
        end
    end

    // Registered read of the active bank.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tap_rd_data_o <= '0;
        end else begin
            tap_rd_data_o <= mem[rd_addr_c];
        end
    end

endmodule

// File: tb/tb_fir_tap_loader.sv
// Self-checking bench for fir_tap_loader: random and sequential bursts checked
// against a burst-level model of the two coefficient banks.
module tb_fir_tap_loader;

    localparam int unsigned TAP_NUM = 128;
`ifdef FIR_TAP_SWAP_ON_ZERO_EN
    localparam bit MACRO   = 1'b1;
    localparam int LAT_UPD = 3;
`else
    localparam bit MACRO   = 1'b0;
    localparam int LAT_UPD = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        burst_end = 1'b0;
    logic        vld = 1'b0;
    logic [31:0] data = '0;
    logic        ren;
    logic        zero_flag = 1'b0;
    logic [6:0]  addr = '0;
    logic [31:0] rd_data;
    logic        bank;
    logic        tvalid;
    logic        upd;
    logic        err;
    logic [15:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model: contents of both banks, active bank, valid flag, error count.
    logic [31:0] mdl [2][TAP_NUM];
    bit          mbank = 1'b0;
    bit          mvalid = 1'b0;
    int          merr = 0;
    logic [31:0] burst_q [$];

    fir_tap_loader #(.TAP_NUM(TAP_NUM), .DATA_WIDTH(32)) dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .track_para_burst_end_i (burst_end),
        .track_para_vld_i       (vld),
        .track_para_data_i      (data),
        .track_para_ren_o       (ren),
        .laser_zero_flag_i      (zero_flag),
        .tap_rd_addr_i          (addr),
        .tap_rd_data_o          (rd_data),
        .tap_bank_o             (bank),
        .tap_valid_o            (tvalid),
        .tap_update_o           (upd),
        .burst_err_o            (err),
        .burst_err_cnt_o        (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Apply a burst of n words to the model; ended = burst_end was sent.
    task automatic model_burst(input int n, input bit ended);
        for (int i = 0; i < n && i < TAP_NUM; i++) mdl[mbank ^ 1'b1][i] = burst_q[i];
        if (ended) begin
            if (n == TAP_NUM) begin
                mbank  = mbank ^ 1'b1;
                mvalid = 1'b1;
            end else if (merr < 65535) begin
                merr++;
            end
        end
    endtask

    task automatic send_words(input int n, input bit seq);
        int waited;
        logic [31:0] w;
        burst_q.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            waited = 0;
            while (!ren && waited < 50) begin
                vld = 1'b0;
                @(negedge clk);
                waited++;
            end
            if (!ren) begin
                n_checks++;
                n_errors++;
                $display("FAIL ren_timeout: ren=%0b required 1 at word %0d", ren, i);
            end
            w    = seq ? 32'(i) : 32'($urandom);
            vld  = 1'b1;
            data = w;
            burst_q.push_back(w);
        end
        @(negedge clk);
        vld = 1'b0;
    endtask

    // Pulse burst_end (optionally with one last word) and measure the cycle
    // distance to the first tap_update_o / burst_err_o pulse (-1 = none).
    task automatic finish_burst(input bit with_word, output int lat_upd, output int lat_err);
        logic [31:0] w;
        lat_upd = -1;
        lat_err = -1;
        @(negedge clk);
        burst_end = 1'b1;
        if (with_word) begin
            w    = 32'($urandom);
            vld  = 1'b1;
            data = w;
            burst_q.push_back(w);
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            burst_end = 1'b0;
            vld       = 1'b0;
            zero_flag = MACRO && (c == 2);
            if (upd && lat_upd < 0) lat_upd = c;
            if (err && lat_err < 0) lat_err = c;
            if (ren && c >= 2 && (lat_upd >= 0 || lat_err >= 0)) break;
        end
        zero_flag = 1'b0;
    endtask

    task automatic read_tap(input int a, output logic [31:0] d);
        @(negedge clk);
        addr = 7'(a);
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic check_reads(input string tag);
        int a;
        logic [31:0] d;
        for (int k = 0; k < 6; k++) begin
            a = $urandom_range(0, TAP_NUM - 1);
            read_tap(a, d);
            n_checks++;
            if (d !== mdl[mbank][a]) begin
                n_errors++;
                $display("FAIL %s_read: addr %0d got %h required %h", tag, a, d, mdl[mbank][a]);
            end
        end
    endtask

    task automatic check_state(input string tag);
        n_checks++;
        if (bank !== mbank || tvalid !== mvalid || err_cnt !== 16'(merr)) begin
            n_errors++;
            $display("FAIL %s_state: bank/valid/errcnt got %0b/%0b/%0d required %0b/%0b/%0d",
                     tag, bank, tvalid, err_cnt, mbank, mvalid, merr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ren !== 1'b1 || rd_data !== 32'd0 || bank !== 1'b0 || tvalid !== 1'b0 ||
            upd !== 1'b0 || err !== 1'b0 || err_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_values: ren=%0b rd=%h bank=%0b valid=%0b upd=%0b err=%0b cnt=%0d required 1/0/0/0/0/0/0",
                     ren, rd_data, bank, tvalid, upd, err, err_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_good_burst();
        int lu, le;
        logic [31:0] d;
        send_words(TAP_NUM, 1'b1);
        finish_burst(1'b0, lu, le);
        model_burst(TAP_NUM, 1'b1);
        n_checks++;
        if (lu != LAT_UPD || le != -1) begin
            n_errors++;
            $display("FAIL good_latency: update %0d err %0d required %0d/-1", lu, le, LAT_UPD);
        end
        n_checks++;
        if (bank !== 1'b1 || tvalid !== 1'b1) begin
            n_errors++;
            $display("FAIL good_bank: bank=%0b valid=%0b required 1/1", bank, tvalid);
        end
        read_tap(5, d);
        n_checks++;
        if (d !== 32'h5) begin
            n_errors++;
            $display("FAIL good_addr5: got %h required 00000005", d);
        end
        check_reads("good");
    endtask

    task automatic test_short_burst();
        int lu, le;
        send_words(100, 1'b0);
        finish_burst(1'b0, lu, le);
        model_burst(100, 1'b1);
        n_checks++;
        if (le != 1 || lu != -1) begin
            n_errors++;
            $display("FAIL short_err: err %0d update %0d required 1/-1", le, lu);
        end
        check_state("short");
        check_reads("short_old");
        send_words(TAP_NUM, 1'b0);
        finish_burst(1'b0, lu, le);
        model_burst(TAP_NUM, 1'b1);
        n_checks++;
        if (lu != LAT_UPD || le != -1) begin
            n_errors++;
            $display("FAIL short_recover: update %0d err %0d required %0d/-1", lu, le, LAT_UPD);
        end
        check_state("short_recover");
        check_reads("short_recover");
    endtask

    task automatic test_long_burst();
        int lu, le;
        send_words(130, 1'b0);
        finish_burst(1'b0, lu, le);
        model_burst(130, 1'b1);
        n_checks++;
        if (le != 1 || lu != -1) begin
            n_errors++;
            $display("FAIL long_err: err %0d update %0d required 1/-1", le, lu);
        end
        check_state("long");
        check_reads("long");
        // 384 words wraps an unsaturated 8-bit count back onto TAP_NUM.
        send_words(384, 1'b0);
        finish_burst(1'b0, lu, le);
        model_burst(384, 1'b1);
        n_checks++;
        if (le != 1 || lu != -1) begin
            n_errors++;
            $display("FAIL saturate_err: err %0d update %0d required 1/-1", le, lu);
        end
        check_state("saturate");
    endtask

    task automatic test_end_with_vld();
        int lu, le;
        send_words(TAP_NUM - 1, 1'b0);
        finish_burst(1'b1, lu, le);
        model_burst(TAP_NUM, 1'b1);
        n_checks++;
        if (lu != LAT_UPD || le != -1) begin
            n_errors++;
            $display("FAIL end_vld: update %0d err %0d required %0d/-1", lu, le, LAT_UPD);
        end
        check_state("end_vld");
        check_reads("end_vld");
    endtask

    task automatic test_end_latched();
        int a;
        bit seen_err;
        logic [31:0] old_d, new_d;
        a = $urandom_range(0, TAP_NUM - 1);
        send_words(TAP_NUM, 1'b0);
        old_d = mdl[mbank][a];
        model_burst(TAP_NUM, 1'b1);
        new_d = mdl[mbank][a];
        seen_err = 1'b0;
        @(negedge clk);
        burst_end = 1'b1;
        addr      = 7'(a);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            burst_end = (c == 1);
            zero_flag = MACRO && (c == 2);
            if (c == LAT_UPD) begin
                n_checks++;
                if (upd !== 1'b1 || rd_data !== old_d) begin
                    n_errors++;
                    $display("FAIL swap_cycle: upd=%0b rd=%h required 1/%h", upd, rd_data, old_d);
                end
            end
            if (c == LAT_UPD + 1) begin
                n_checks++;
                if (upd !== 1'b0 || rd_data !== new_d) begin
                    n_errors++;
                    $display("FAIL after_swap: upd=%0b rd=%h required 0/%h", upd, rd_data, new_d);
                end
            end
            if (err) seen_err = 1'b1;
        end
        burst_end = 1'b0;
        zero_flag = 1'b0;
        if (merr < 65535) merr++;
        n_checks++;
        if (seen_err !== 1'b1) begin
            n_errors++;
            $display("FAIL latched_end: err pulse seen %0b required 1", seen_err);
        end
        check_state("latched");
    endtask

    task automatic test_back_to_back();
        int lu, le;
        for (int b = 0; b < 2; b++) begin
            send_words(TAP_NUM, 1'b0);
            finish_burst(1'b0, lu, le);
            model_burst(TAP_NUM, 1'b1);
            n_checks++;
            if (lu != LAT_UPD || le != -1) begin
                n_errors++;
                $display("FAIL b2b_latency: burst %0d update %0d err %0d required %0d/-1", b, lu, le, LAT_UPD);
            end
            check_state("b2b");
            check_reads("b2b");
        end
    endtask

    task automatic test_reset_mid();
        int lu, le;
        send_words(60, 1'b0);
        model_burst(60, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        mbank  = 1'b0;
        mvalid = 1'b0;
        merr   = 0;
        check_state("reset_mid");
        send_words(TAP_NUM, 1'b0);
        finish_burst(1'b0, lu, le);
        model_burst(TAP_NUM, 1'b1);
        n_checks++;
        if (lu != LAT_UPD || bank !== 1'b1 || err_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_mid_commit: update %0d bank %0b cnt %0d required %0d/1/0", lu, bank, err_cnt, LAT_UPD);
        end
        check_reads("reset_mid");
    endtask

    task automatic test_pend_hold();
        bit bad;
        send_words(TAP_NUM, 1'b0);
        @(negedge clk);
        burst_end = 1'b1;
        @(negedge clk);
        burst_end = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (ren !== 1'b0 || upd !== 1'b0 || bank !== mbank) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_errors++;
            $display("FAIL pend_hold: ren/update/bank changed while waiting, required 0/0/%0b", mbank);
        end
        zero_flag = 1'b1;
        @(negedge clk);
        zero_flag = 1'b0;
        model_burst(TAP_NUM, 1'b1);
        n_checks++;
        if (upd !== 1'b1 || bank !== mbank) begin
            n_errors++;
            $display("FAIL pend_commit: upd=%0b bank=%0b required 1/%0b", upd, bank, mbank);
        end
        check_reads("pend");
    endtask

    initial begin
        test_reset();
        test_good_burst();
        test_short_burst();
        test_long_burst();
        test_end_with_vld();
        test_end_latched();
        test_back_to_back();
        if (MACRO) test_pend_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
